// File: rtl/ifu_prefetch_pkg.sv
// Shared bus widths, constants and FSM encodings for the instruction-fetch unit.
package ifu_prefetch_pkg;

    localparam int          SramBus     = 32;
    localparam int          SramAddrBus = 32;
    localparam logic [31:0] ZeroWord    = 32'h0000_0000;
    localparam logic [31:0] INST_NOP    = 32'h0000_0013;
    localparam logic        JumpEnable  = 1'b1;

    typedef enum logic [1:0] {
        IfuBoot  = 2'd0,
        IfuRun   = 2'd1,
        IfuDrain = 2'd2
    } ifu_state_e;

    function automatic logic [SramAddrBus-1:0] pc_next(input logic [SramAddrBus-1:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/ifu_fifo.sv
// Small synchronous FIFO with flush; storage registered, head read directly (no bypass).
module ifu_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty,
    output logic [CW-1:0]    o_count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             w_pop;
    logic             w_push;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_rdata = r_mem[r_rptr];

    assign w_pop  = i_pop & ~o_empty & ~i_flush;
    assign w_push = i_push & ~i_flush & (~o_full | w_pop);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // Payload storage carries no reset; validity is owned by the pointers.
    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wptr] <= i_wdata;
    end

endmodule

// File: rtl/ifu_prefetch.sv
// Instruction-fetch unit: owns the PC, issues credit-limited SRAM fetches, buffers responses.
// Optional IFU_MISALIGN_CHECK_EN adds misaligned_o and blocks fetch on unaligned jump targets.
module ifu_prefetch
    import ifu_prefetch_pkg::*;
#(
    parameter logic [SramAddrBus-1:0] RESET_PC = 32'h0000_0000,
    parameter int                     DEPTH    = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   jump_flag_ex_i,
    input  logic [SramAddrBus-1:0] jump_addr_ex_i,
    input  logic                   hold_i,
    output logic                   ibus_req_o,
    output logic [SramAddrBus-1:0] ibus_addr_o,
    input  logic                   ibus_gnt_i,
    input  logic                   ibus_rvalid_i,
    input  logic [SramBus-1:0]     ibus_rdata_i,
    output logic [SramBus-1:0]     inst_o,
    output logic [SramAddrBus-1:0] inst_addr_o,
    output logic                   inst_valid_o
`ifdef IFU_MISALIGN_CHECK_EN
    ,
    output logic                   misaligned_o
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int EW = SramAddrBus + SramBus;

    ifu_state_e             r_state;
    ifu_state_e             w_state_nxt;
    logic [SramAddrBus-1:0] r_pc;
    logic [SramAddrBus-1:0] r_resp_pc;
    logic [SramAddrBus-1:0] w_tgt;
    logic [CW-1:0]          r_out;
    logic [CW-1:0]          r_drop;
    logic [CW-1:0]          w_out_nxt;
    logic [CW-1:0]          w_drop_nxt;
    logic [CW-1:0]          w_count;
    logic [CW:0]            w_used;
    logic                   w_jump;
    logic                   w_pop;
    logic                   w_grant;
    logic                   w_rsp_ret;
    logic                   w_drop_rsp;
    logic                   w_push;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_mis_block;
    logic [EW-1:0]          w_head;

    assign w_jump = (jump_flag_ex_i == JumpEnable);

`ifdef IFU_MISALIGN_CHECK_EN
    logic r_mis;

    assign w_tgt        = jump_addr_ex_i;
    assign w_mis_block  = r_mis;
    assign misaligned_o = r_mis;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)        r_mis <= 1'b0;
        else if (w_jump) r_mis <= (jump_addr_ex_i[1:0] != 2'b00);
    end
`else
    assign w_tgt       = jump_addr_ex_i & ~32'h3;
    assign w_mis_block = 1'b0;
`endif

    // Occupancy is taken after this cycle's pop so a full pipe still streams one word per cycle.
    assign w_pop      = inst_valid_o & ~hold_i & ~w_jump;
    assign w_used     = {1'b0, r_out} + {1'b0, w_count} - {{CW{1'b0}}, w_pop};
    assign ibus_req_o = (r_state != IfuBoot) & ~w_jump & ~w_mis_block
                      & (w_used < (CW+1)'(DEPTH));
    assign ibus_addr_o = r_pc;

    assign w_grant    = ibus_req_o & ibus_gnt_i;
    assign w_rsp_ret  = ibus_rvalid_i & (r_out != '0);
    assign w_drop_rsp = ibus_rvalid_i & (w_jump | (r_drop != '0));
    assign w_push     = ibus_rvalid_i & ~w_drop_rsp & (~w_full | w_pop);
    assign w_out_nxt  = r_out + CW'(w_grant) - CW'(w_rsp_ret);

    // On a jump everything still on the bus becomes discard-pending.
    always_comb begin
        w_drop_nxt = r_drop;
        if (w_jump)
            w_drop_nxt = w_out_nxt;
        else if (ibus_rvalid_i && (r_drop != '0))
            w_drop_nxt = r_drop - 1'b1;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IfuBoot:  w_state_nxt = IfuRun;
            IfuRun:   if (w_drop_nxt != '0) w_state_nxt = IfuDrain;
            IfuDrain: if (w_drop_nxt == '0) w_state_nxt = IfuRun;
            default:  w_state_nxt = IfuBoot;
        endcase
    end

    // r_resp_pc is the address of the next response that will be kept.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IfuBoot;
            r_pc      <= RESET_PC;
            r_resp_pc <= RESET_PC;
            r_out     <= '0;
            r_drop    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_out   <= w_out_nxt;
            r_drop  <= w_drop_nxt;
            if (w_jump)
                r_pc <= w_tgt;
            else if (w_grant)
                r_pc <= pc_next(r_pc);
            if (w_jump)
                r_resp_pc <= w_tgt;
            else if (w_push)
                r_resp_pc <= pc_next(r_resp_pc);
        end
    end

    ifu_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_fifo (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_flush (w_jump),
        .i_push  (w_push),
        .i_wdata ({r_resp_pc, ibus_rdata_i}),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign inst_valid_o = ~w_empty;
    assign inst_o       = w_empty ? INST_NOP : w_head[SramBus-1:0];
    assign inst_addr_o  = w_empty ? ZeroWord : w_head[EW-1:SramBus];

endmodule

// File: tb/tb_ifu_prefetch.sv
// Bench for ifu_prefetch: randomized bus/jump/hold stimulus against a transaction-level queue model.
module tb_ifu_prefetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 2;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        jump_flag_ex_i = 1'b0;
    logic [31:0] jump_addr_ex_i = '0;
    logic        hold_i = 1'b0;
    logic        ibus_req_o;
    logic [31:0] ibus_addr_o;
    logic        ibus_gnt_i = 1'b0;
    logic        ibus_rvalid_i = 1'b0;
    logic [31:0] ibus_rdata_i = '0;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;
    logic        inst_valid_o;
`ifdef IFU_MISALIGN_CHECK_EN
    logic        misaligned_o;
`endif

    ifu_prefetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .jump_flag_ex_i (jump_flag_ex_i),
        .jump_addr_ex_i (jump_addr_ex_i),
        .hold_i         (hold_i),
        .ibus_req_o     (ibus_req_o),
        .ibus_addr_o    (ibus_addr_o),
        .ibus_gnt_i     (ibus_gnt_i),
        .ibus_rvalid_i  (ibus_rvalid_i),
        .ibus_rdata_i   (ibus_rdata_i),
        .inst_o         (inst_o),
        .inst_addr_o    (inst_addr_o),
        .inst_valid_o   (inst_valid_o)
`ifdef IFU_MISALIGN_CHECK_EN
        ,
        .misaligned_o   (misaligned_o)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Reference model: PC, prefetch buffer contents, discard budget, bus in-flight queue.
    logic [31:0] m_pc;
    logic [31:0] m_fifo[$];
    int          m_drop;
    bit          m_boot;
    bit          m_mis;
    logic [31:0] q_addr[$];
    int          q_due[$];
    int          g_mode = 0;
    int          lat_min = 1;
    int          lat_max = 1;

    function automatic logic [31:0] mk_data(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction

    task automatic step(input bit jmp, input logic [31:0] tgt, input bit hld);
        bit          pop, exp_req, grant, rv;
        logic [31:0] ra, e_addr, e_inst, t_eff;
        int          td;
        @(posedge clk); #1;
        rst = 1'b1;
        jump_flag_ex_i = jmp;
        jump_addr_ex_i = tgt;
        hold_i = hld;
        case (g_mode)
            0:       ibus_gnt_i = 1'b1;
            1:       ibus_gnt_i = 1'b0;
            default: ibus_gnt_i = 1'($urandom_range(0, 1));
        endcase
        rv = (q_addr.size() > 0) && (q_due[0] <= cyc);
        ibus_rvalid_i = rv;
        ibus_rdata_i = rv ? mk_data(q_addr[0]) : $urandom;
        #1;
        pop = (m_fifo.size() > 0) && !hld && !jmp;
        exp_req = !m_boot && !jmp && !m_mis
                  && (q_addr.size() + m_fifo.size() - int'(pop) < DEPTH);
        e_addr = (m_fifo.size() > 0) ? m_fifo[0] : 32'h0;
        e_inst = (m_fifo.size() > 0) ? mk_data(m_fifo[0]) : NOP;

        checks++;
        if (ibus_req_o !== exp_req) begin
            failures++;
            $display("FAIL req cyc=%0d got=%b exp=%b", cyc, ibus_req_o, exp_req);
        end
        checks++;
        if (ibus_addr_o !== m_pc) begin
            failures++;
            $display("FAIL ibus_addr cyc=%0d got=%h exp=%h", cyc, ibus_addr_o, m_pc);
        end
        checks++;
        if (inst_valid_o !== (m_fifo.size() > 0)) begin
            failures++;
            $display("FAIL inst_valid cyc=%0d got=%b exp=%b", cyc, inst_valid_o, m_fifo.size() > 0);
        end
        checks++;
        if (inst_addr_o !== e_addr) begin
            failures++;
            $display("FAIL inst_addr cyc=%0d got=%h exp=%h", cyc, inst_addr_o, e_addr);
        end
        checks++;
        if (inst_o !== e_inst) begin
            failures++;
            $display("FAIL inst cyc=%0d got=%h exp=%h", cyc, inst_o, e_inst);
        end
        if (rv && !jmp && m_drop == 0) begin
            checks++;
            if (m_fifo.size() >= DEPTH) begin
                failures++;
                $display("FAIL rvalid_while_full cyc=%0d occupancy=%0d limit<%0d", cyc, m_fifo.size(), DEPTH);
            end
        end
`ifdef IFU_MISALIGN_CHECK_EN
        checks++;
        if (misaligned_o !== m_mis) begin
            failures++;
            $display("FAIL misaligned cyc=%0d got=%b exp=%b", cyc, misaligned_o, m_mis);
        end
`endif

        grant = exp_req && ibus_gnt_i;
        if (pop) ra = m_fifo.pop_front();
        if (rv) begin
            ra = q_addr.pop_front();
            td = q_due.pop_front();
            if (!jmp) begin
                if (m_drop > 0) m_drop--;
                else m_fifo.push_back(ra);
            end
        end
        if (grant) begin
            q_addr.push_back(m_pc);
            q_due.push_back(cyc + int'($urandom_range(lat_min, lat_max)));
            m_pc = m_pc + 32'd4;
        end
        if (jmp) begin
`ifdef IFU_MISALIGN_CHECK_EN
            t_eff = tgt;
            m_mis = (tgt[1:0] != 2'b00);
`else
            t_eff = tgt & ~32'h3;
`endif
            m_fifo.delete();
            m_pc = t_eff;
            m_drop = q_addr.size();
        end
        m_boot = 1'b0;
        cyc++;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        jump_flag_ex_i = 1'b0;
        hold_i = 1'b0;
        ibus_gnt_i = 1'b0;
        ibus_rvalid_i = 1'b0;
        repeat (2) @(posedge clk);
        q_addr.delete();
        q_due.delete();
        m_fifo.delete();
        m_pc = RESET_PC;
        m_drop = 0;
        m_mis = 1'b0;
        m_boot = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        #2;
        checks++; if (ibus_req_o !== 1'b0) begin failures++; $display("FAIL rst_req got=%b exp=0", ibus_req_o); end
        checks++; if (ibus_addr_o !== RESET_PC) begin failures++; $display("FAIL rst_addr got=%h exp=%h", ibus_addr_o, RESET_PC); end
        checks++; if (inst_valid_o !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", inst_valid_o); end
        checks++; if (inst_o !== NOP) begin failures++; $display("FAIL rst_inst got=%h exp=%h", inst_o, NOP); end
        checks++; if (inst_addr_o !== 32'h0) begin failures++; $display("FAIL rst_inst_addr got=%h exp=0", inst_addr_o); end
`ifdef IFU_MISALIGN_CHECK_EN
        checks++; if (misaligned_o !== 1'b0) begin failures++; $display("FAIL rst_mis got=%b exp=0", misaligned_o); end
`endif
        g_mode = 0; lat_min = 1; lat_max = 1;
        repeat (6) step(1'b0, 32'h0, 1'b0);
        // Reset takes effect without waiting for a clock edge.
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        checks++; if (inst_valid_o !== 1'b0) begin failures++; $display("FAIL async_rst_valid got=%b exp=0", inst_valid_o); end
        checks++; if (ibus_addr_o !== RESET_PC) begin failures++; $display("FAIL async_rst_addr got=%h exp=%h", ibus_addr_o, RESET_PC); end
    endtask

    task automatic test_stream();
        int first = -1;
        int nvalid = 0;
        logic [31:0] first_addr = 32'hDEAD_BEEF;
        do_reset();
        g_mode = 0; lat_min = 1; lat_max = 1;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 32'h0, 1'b0);
            if (inst_valid_o === 1'b1) begin
                if (first < 0) begin first = i; first_addr = inst_addr_o; end
                nvalid++;
            end
        end
        checks++; if (first != 3) begin failures++; $display("FAIL stream_first_valid got=%0d exp=3", first); end
        checks++; if (first_addr !== RESET_PC) begin failures++; $display("FAIL stream_first_addr got=%h exp=%h", first_addr, RESET_PC); end
        checks++; if (nvalid != 17) begin failures++; $display("FAIL stream_throughput got=%0d exp=17", nvalid); end
    endtask

    task automatic test_hold();
        logic [31:0] held;
        do_reset();
        g_mode = 0; lat_min = 1; lat_max = 1;
        repeat (6) step(1'b0, 32'h0, 1'b0);
        step(1'b0, 32'h0, 1'b1);
        held = inst_o;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 32'h0, 1'b1);
            checks++;
            if (inst_o !== held) begin failures++; $display("FAIL hold_stable i=%0d got=%h exp=%h", i, inst_o, held); end
        end
        checks++; if (ibus_req_o !== 1'b0) begin failures++; $display("FAIL hold_req got=%b exp=0", ibus_req_o); end
        repeat (8) step(1'b0, 32'h0, 1'b0);
    endtask

    task automatic test_jump_outstanding();
        bit seen = 1'b0;
        do_reset();
        g_mode = 0; lat_min = 3; lat_max = 3;
        repeat (3) step(1'b0, 32'h0, 1'b0);
        step(1'b1, 32'h0000_0100, 1'b0);
        for (int i = 0; i < 20 && !seen; i++) begin
            step(1'b0, 32'h0, 1'b0);
            if (inst_valid_o === 1'b1) begin
                seen = 1'b1;
                checks++;
                if (inst_addr_o !== 32'h100) begin failures++; $display("FAIL jump_first_addr got=%h exp=00000100", inst_addr_o); end
                checks++;
                if (inst_o !== mk_data(32'h100)) begin failures++; $display("FAIL jump_first_inst got=%h exp=%h", inst_o, mk_data(32'h100)); end
            end
        end
        if (!seen) begin
            checks++; failures++;
            $display("FAIL jump_timeout got=no_valid exp=valid_within_20");
        end
    endtask

    task automatic test_jump_rvalid_hold();
        do_reset();
        g_mode = 0; lat_min = 1; lat_max = 1;
        repeat (6) step(1'b0, 32'h0, 1'b0);
        step(1'b1, 32'h0000_0040, 1'b1);
        step(1'b0, 32'h0, 1'b0);
        checks++; if (inst_valid_o !== 1'b0) begin failures++; $display("FAIL jrh_valid got=%b exp=0", inst_valid_o); end
        checks++; if (inst_o !== NOP) begin failures++; $display("FAIL jrh_inst got=%h exp=%h", inst_o, NOP); end
        repeat (6) step(1'b0, 32'h0, 1'b0);
    endtask

    task automatic test_gnt_low();
        logic [31:0] a0;
        do_reset();
        g_mode = 1; lat_min = 4; lat_max = 4;
        step(1'b0, 32'h0, 1'b0);
        a0 = ibus_addr_o;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 32'h0, 1'b0);
            checks++;
            if (ibus_addr_o !== a0 || ibus_req_o !== 1'b1) begin
                failures++;
                $display("FAIL gnt_low_hold i=%0d got=%h/%b exp=%h/1", i, ibus_addr_o, ibus_req_o, a0);
            end
        end
        g_mode = 0;
        repeat (20) step(1'b0, 32'h0, 1'b0);
    endtask

    task automatic test_wrap();
        do_reset();
        g_mode = 0; lat_min = 1; lat_max = 1;
        repeat (4) step(1'b0, 32'h0, 1'b0);
        step(1'b1, 32'hFFFF_FFFC, 1'b0);
        step(1'b0, 32'h0, 1'b0);
        checks++; if (ibus_addr_o !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_target got=%h exp=fffffffc", ibus_addr_o); end
        step(1'b0, 32'h0, 1'b0);
        checks++; if (ibus_addr_o !== 32'h0) begin failures++; $display("FAIL wrap_next got=%h exp=00000000", ibus_addr_o); end
        repeat (4) step(1'b0, 32'h0, 1'b0);
        step(1'b1, 32'h0000_0102, 1'b0);
        step(1'b0, 32'h0, 1'b0);
`ifdef IFU_MISALIGN_CHECK_EN
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (misaligned_o !== 1'b1 || ibus_req_o !== 1'b0) begin
                failures++;
                $display("FAIL misalign_block i=%0d got=%b/%b exp=1/0", i, misaligned_o, ibus_req_o);
            end
            step(1'b0, 32'h0, 1'b0);
        end
        step(1'b1, 32'h0000_0200, 1'b0);
        step(1'b0, 32'h0, 1'b0);
        checks++; if (misaligned_o !== 1'b0) begin failures++; $display("FAIL misalign_clear got=%b exp=0", misaligned_o); end
`else
        checks++; if (ibus_addr_o !== 32'h100) begin failures++; $display("FAIL align_force got=%h exp=00000100", ibus_addr_o); end
`endif
        repeat (6) step(1'b0, 32'h0, 1'b0);
    endtask

    task automatic test_random();
        bit          j, h;
        logic [31:0] t;
        do_reset();
        g_mode = 2; lat_min = 1; lat_max = 4;
        for (int i = 0; i < 2000; i++) begin
            j = ($urandom_range(0, 19) == 0);
            h = ($urandom_range(0, 9) < 3);
            t = {$urandom_range(0, 255), 2'b00};
            if ($urandom_range(0, 7) == 0) t[1:0] = 2'($urandom_range(1, 3));
            if ($urandom_range(0, 15) == 0) t = 32'hFFFF_FFF8;
            step(j, t, h);
        end
        g_mode = 0; lat_min = 1; lat_max = 2;
        repeat (10) step(1'b0, 32'h0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_stream();
        test_hold();
        test_jump_outstanding();
        test_jump_rvalid_hold();
        test_gnt_low();
        test_wrap();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
